// File: rtl/lsu_ctrl_if.sv
// Core-side request/response handshake and word-RAM port of the load/store unit.
interface lsu_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] dAddr;
    logic [XLEN-1:0] dWdata;
    logic [XLEN-1:0] dRdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dRdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, wstrb, dAddr, dWdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dRdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, wstrb, dAddr, dWdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: one outstanding request, byte-lane strobes and
// lane-replicated store data toward a word RAM, extended load data back.
module lsu_ctrl #(
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lane_q, lane_d;
    logic            req_ready_q;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] daddr_q, daddr_d;
    logic [XLEN-1:0] dwdata_q, dwdata_d;

    // Misalignment or funct3 that has no meaning for the access direction.
    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic err;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = a[0];
            3'b010:  err = |a;
            3'b100:  err = we;
            3'b101:  err = we | a[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [XLEN-1:0] word);
        logic [XLEN-1:0] shifted;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        shifted = word >> {a, 3'b000};
        b       = shifted[7:0];
        h       = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wstrb_d     = 4'b0000;
        daddr_d     = '0;
        dwdata_d    = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    lane_d   = bus.req_addr[1:0];
                    if (access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        daddr_d = {bus.req_addr[31:2], 2'b00};
                        if (bus.req_we) begin
                            case (bus.req_funct3)
                                3'b000: begin
                                    wstrb_d  = 4'(4'b0001 << bus.req_addr[1:0]);
                                    dwdata_d = {4{bus.req_wdata[7:0]}};
                                end
                                3'b001: begin
                                    wstrb_d  = 4'(4'b0011 << {bus.req_addr[1], 1'b0});
                                    dwdata_d = {2{bus.req_wdata[15:0]}};
                                end
                                default: begin
                                    wstrb_d  = 4'b1111;
                                    dwdata_d = bus.req_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                if (!we_q && (RD_LATENCY == 1)) begin
                    state_d = WAIT;
                    daddr_d = daddr_q;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : load_extract(funct3_q, lane_q, bus.dRdata);
                end
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = load_extract(funct3_q, lane_q, bus.dRdata);
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Async reset clears strobes immediately, so a store cut short never writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            lane_q      <= 2'b00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wstrb_q     <= 4'b0000;
            daddr_q     <= '0;
            dwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wstrb_q     <= wstrb_d;
            daddr_q     <= daddr_d;
            dwdata_q    <= dwdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.dAddr     = daddr_q;
    assign bus.dWdata    = dwdata_q;
endmodule
